// File: rtl/vme_bus_buffer_ctrl.sv
// Break-before-make sequencer for the SVEC VME address/data transceivers and DTACK driver.
// Every direction change is preceded by a dead window with all buffer enables released.
module vme_bus_buffer_ctrl #(
    parameter int unsigned g_DEAD_CYCLES   = 2,
    parameter int unsigned g_SETTLE_CYCLES = 1
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic vme_as_n_i,
    input  logic rd_req_i,
    input  logic wr_req_i,
    input  logic mblt_i,
    input  logic dtack_req_i,
    input  logic release_i,
    output logic ready_o,
    output logic dtack_oe_o,
    output logic vme_addr_dir_o,
    output logic vme_addr_oe_n_o,
    output logic vme_data_dir_o,
    output logic vme_data_oe_n_o
);

    typedef enum logic [2:0] {
        S_ADDR,
        S_OFF,
        S_DIR,
        S_ON,
        S_READY,
        S_RET,
        S_RDIR
    } state_t;

    localparam logic [3:0] DEAD   = 4'(g_DEAD_CYCLES);
    localparam logic [3:0] SETTLE = 4'(g_SETTLE_CYCLES);

    state_t     state, state_nx;
    logic [3:0] cnt, cnt_nx;
    logic       tgt_rd, tgt_rd_nx;
    logic       tgt_addr_out, tgt_addr_out_nx;
    logic       abort;
    logic       addr_oe_n_nx, data_oe_n_nx, addr_dir_nx, data_dir_nx;
    logic       ready_nx, dtack_oe_nx;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state           <= S_RET;
            cnt             <= DEAD;
            tgt_rd          <= 1'b0;
            tgt_addr_out    <= 1'b0;
            ready_o         <= 1'b0;
            dtack_oe_o      <= 1'b0;
            vme_addr_dir_o  <= 1'b0;
            vme_addr_oe_n_o <= 1'b1;
            vme_data_dir_o  <= 1'b0;
            vme_data_oe_n_o <= 1'b1;
        end else begin
            state           <= state_nx;
            cnt             <= cnt_nx;
            tgt_rd          <= tgt_rd_nx;
            tgt_addr_out    <= tgt_addr_out_nx;
            ready_o         <= ready_nx;
            dtack_oe_o      <= dtack_oe_nx;
            vme_addr_dir_o  <= addr_dir_nx;
            vme_addr_oe_n_o <= addr_oe_n_nx;
            vme_data_dir_o  <= data_dir_nx;
            vme_data_oe_n_o <= data_oe_n_nx;
        end
    end

    always_comb begin
        state_nx        = state;
        cnt_nx          = cnt;
        tgt_rd_nx       = tgt_rd;
        tgt_addr_out_nx = tgt_addr_out;
        abort           = release_i | vme_as_n_i;

        case (state)
            S_ADDR: begin
                // rd_req_i has priority; mblt_i only matters for reads
                if (!vme_as_n_i && (rd_req_i || wr_req_i)) begin
                    state_nx        = S_OFF;
                    cnt_nx          = DEAD;
                    tgt_rd_nx       = rd_req_i;
                    tgt_addr_out_nx = rd_req_i & mblt_i;
                end
            end
            S_OFF: begin
                if (abort) begin
                    state_nx = S_RET;
                    cnt_nx   = DEAD;
                end else if (cnt <= 4'd1) begin
                    state_nx = S_DIR;
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            S_DIR: begin
                if (abort) begin
                    state_nx = S_RET;
                    cnt_nx   = DEAD;
                end else begin
                    state_nx = S_ON;
                    cnt_nx   = SETTLE;
                end
            end
            S_ON: begin
                if (abort) begin
                    state_nx = S_RET;
                    cnt_nx   = DEAD;
                end else if (cnt <= 4'd1) begin
                    state_nx = S_READY;
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            S_READY: begin
                if (abort) begin
                    state_nx = S_RET;
                    cnt_nx   = DEAD;
                end
            end
            S_RET: begin
                if (cnt <= 4'd1) begin
                    state_nx = S_RDIR;
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            S_RDIR: begin
                state_nx = S_ADDR;
            end
            default: begin
                state_nx = S_RET;
                cnt_nx   = DEAD;
            end
        endcase

        // Outputs are decoded from the next state so that they register with it
        addr_oe_n_nx = !(state_nx inside {S_ADDR, S_ON, S_READY});
        data_oe_n_nx = !(state_nx inside {S_ON, S_READY});
        ready_nx     = (state_nx == S_READY);
        dtack_oe_nx  = ready_nx & dtack_req_i;
        addr_dir_nx  = vme_addr_dir_o;
        data_dir_nx  = vme_data_dir_o;
        if (state_nx == S_DIR) begin
            addr_dir_nx = tgt_addr_out_nx;
            data_dir_nx = tgt_rd_nx;
        end else if (state_nx inside {S_RDIR, S_ADDR}) begin
            addr_dir_nx = 1'b0;
            data_dir_nx = 1'b0;
        end
    end

endmodule
